bp_be_branch_resolve: RTL and testbench
=======================================

Name: bp_be_branch_resolve

Overview:
- Consumes the resolved branch outcome of the integer pipe (branch flag, taken flag, next PC, misaligned flag) one cycle after execute.
- Compares each outcome against the frontend-predicted next PC.
- On a mispredict or misaligned target, issues a held valid/ready redirect command to the frontend, then squashes wrong-path results until the backend flush arrives.
- On a correct prediction, pulses an attaboy (training) signal; keeps saturating branch and mispredict statistics.

Parameters:
- vaddr_width_p, 39, virtual address width of PCs and targets
- cnt_width_p, 32, width of each statistics counter

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  integer-pipe result valid this cycle
- branch_i  in  1  result belongs to a branch/jump
- btaken_i  in  1  branch/jump resolved taken
- npc_i  in  vaddr_width_p  resolved next PC
- pred_npc_i  in  vaddr_width_p  frontend-predicted next PC carried with the instruction
- pc_i  in  vaddr_width_p  PC of the branch
- misaligned_i  in  1  resolved taken target is instruction-misaligned
- flush_i  in  1  backend pipeline flush
- busy_o  out  1  high when state is not RUN; upstream must not expect acceptance
- redirect_v_o  out  1  redirect command valid
- redirect_ready_i  in  1  frontend accepts redirect
- redirect_npc_o  out  vaddr_width_p  redirect target
- redirect_pc_o  out  vaddr_width_p  PC of the offending branch
- redirect_reason_o  out  2  0 = mispredict-not-taken, 1 = mispredict-taken, 2 = misaligned, 3 = reserved
- attaboy_v_o  out  1  one-cycle pulse: correct prediction
- attaboy_pc_o  out  vaddr_width_p  PC of correctly predicted branch
- attaboy_taken_o  out  1  resolved direction for the attaboy
- branch_cnt_o  out  cnt_width_p  resolved branches counted
- mispredict_cnt_o  out  cnt_width_p  mispredicts counted

Behaviour:
- Reset (reset_n_i low, async):
  - state = RUN; capture register invalid.
  - All outputs 0, counters 0.
- Capture stage:
  - Register loads pc/npc/pred/taken/misaligned when v_i & branch_i & state==RUN & !flush_i; otherwise its valid clears.
  - Non-branch results (branch_i = 0) are ignored entirely.
  - Inputs presented while busy_o = 1 are dropped.
- Evaluate (cycle after capture, capture valid, state RUN, no flush_i):
  - misaligned = 1 → SEND, reason 2. Misaligned takes precedence over mispredict.
  - Else npc != pred_npc → SEND, reason = {0, taken}.
  - Else attaboy_v_o = 1 for that cycle with the captured pc/taken; state stays RUN.
  - Latency from v_i to redirect_v_o or attaboy_v_o: exactly 1 cycle.
- States:
  - RUN → SEND on redirect condition.
  - SEND holds redirect_v_o = 1 with npc/pc/reason stable until redirect_ready_i. On ready: go to SQUASH, or to RUN if flush_i is high in the same cycle.
  - flush_i alone in SEND does not cancel the redirect.
  - SQUASH: redirect_v_o = 0; all inputs dropped; flush_i → RUN.
  - flush_i in RUN invalidates the capture register; no attaboy or redirect results from that entry.
- Counters:
  - branch_cnt_o +1 on each evaluation in RUN (attaboy or redirect).
  - mispredict_cnt_o +1 on each RUN→SEND with reason 0 or 1.
  - Both saturate at all-ones and never wrap.
- redirect_v_o must not depend combinationally on redirect_ready_i.
- Evaluating a new entry is impossible while busy, so no back-to-back redirect overlap.

Test Plan:
- Correct taken: v=1, branch=1, taken=1, npc=pred=0x1000, pc=0xFFC → next cycle attaboy_v_o=1, attaboy_pc_o=0xFFC, taken=1; branch_cnt_o=1, mispredict_cnt_o=0, no redirect.
- Mispredict, ready held low 3 cycles: npc=0x2000, pred=0x1004 → redirect_v_o=1 held 3+ cycles with npc 0x2000, reason 1; on ready → SQUASH, busy_o=1. A v_i branch arriving in SQUASH is dropped, counters unchanged. flush_i → RUN.
- Misaligned plus mismatch: misaligned=1, npc=0x1002, pred=0x1004 → reason 2; mispredict_cnt_o unchanged, branch_cnt_o +1.
- Same-cycle ready and flush_i in SEND → next state RUN, busy_o=0 the following cycle; a new branch is accepted immediately.
- Flush during capture: v_i branch at cycle N, flush_i at N+1 → no attaboy or redirect, counters unchanged.
- Async reset asserted mid-SEND (between clock edges) → redirect_v_o=0 immediately; counters=0; after release, state is RUN.

Source files
------------

// File: rtl/bp_be_branch_resolve.sv
// ---------------------------------------------------------------------------
// bp_be_branch_resolve
//
// Purpose:
//   Takes the resolved branch outcome from the integer pipe, which arrives one
//   cycle after execute, and registers it in a capture stage. In the following
//   cycle it compares the resolved next PC with the PC the frontend predicted.
//     - Misaligned taken target : redirect the frontend, reason 2.
//     - Next-PC mismatch        : redirect the frontend, reason {0, taken}.
//     - Correct prediction      : one-cycle attaboy pulse for predictor training.
//   A redirect is offered with a valid/ready handshake, and its payload stays
//   stable until it is accepted. After acceptance, wrong-path results are
//   squashed until the backend flush arrives. Saturating counters track the
//   number of branches resolved and the number of mispredicts.
//
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   v_i, branch_i            result valid / result belongs to a branch or jump
//   btaken_i, misaligned_i   resolved direction / taken target misaligned
//   npc_i, pred_npc_i, pc_i  resolved next PC, predicted next PC, branch PC
//   flush_i                  backend pipeline flush
//   busy_o                   unit is not in RUN; new results are dropped
//   redirect_*               redirect command to the frontend (valid/ready)
//   attaboy_*                correct-prediction pulse with PC and direction
//   branch_cnt_o             branches evaluated (saturating)
//   mispredict_cnt_o         direction/target mispredicts (saturating)
// ---------------------------------------------------------------------------
module bp_be_branch_resolve #(
  parameter int vaddr_width_p = 39,
  parameter int cnt_width_p   = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     v_i,
  input  logic                     branch_i,
  input  logic                     btaken_i,
  input  logic [vaddr_width_p-1:0] npc_i,
  input  logic [vaddr_width_p-1:0] pred_npc_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic                     misaligned_i,
  input  logic                     flush_i,

  output logic                     busy_o,

  output logic                     redirect_v_o,
  input  logic                     redirect_ready_i,
  output logic [vaddr_width_p-1:0] redirect_npc_o,
  output logic [vaddr_width_p-1:0] redirect_pc_o,
  output logic [1:0]               redirect_reason_o,

  output logic                     attaboy_v_o,
  output logic [vaddr_width_p-1:0] attaboy_pc_o,
  output logic                     attaboy_taken_o,

  output logic [cnt_width_p-1:0]   branch_cnt_o,
  output logic [cnt_width_p-1:0]   mispredict_cnt_o
);

  // -------------------------------------------------------------------------
  // Redirect reason encodings
  // -------------------------------------------------------------------------
  localparam logic [1:0] reason_misaligned = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SEND   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e state_reg, state_next;

  // -------------------------------------------------------------------------
  // Capture stage
  // -------------------------------------------------------------------------
  logic                     cap_v_reg;
  logic [vaddr_width_p-1:0] cap_pc_reg;
  logic [vaddr_width_p-1:0] cap_npc_reg;
  logic [vaddr_width_p-1:0] cap_pred_reg;
  logic                     cap_taken_reg;
  logic                     cap_mis_reg;

  logic capture_en;

  // Results that are not branches are ignored. Results are also dropped when
  // the unit is busy or when a flush is in progress.
  assign capture_en = v_i & branch_i & (state_reg == RUN) & ~flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cap_v_reg     <= 1'b0;
      cap_pc_reg    <= '0;
      cap_npc_reg   <= '0;
      cap_pred_reg  <= '0;
      cap_taken_reg <= 1'b0;
      cap_mis_reg   <= 1'b0;
    end else begin
      cap_v_reg <= capture_en;
      if (capture_en) begin
        cap_pc_reg    <= pc_i;
        cap_npc_reg   <= npc_i;
        cap_pred_reg  <= pred_npc_i;
        cap_taken_reg <= btaken_i;
        cap_mis_reg   <= misaligned_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Evaluate stage
  // -------------------------------------------------------------------------
  logic       eval_v;
  logic       npc_mismatch;
  logic       redirect_now;
  logic       attaboy_now;
  logic [1:0] eval_reason;

  // A flush in the evaluate cycle cancels the captured entry, because that
  // entry is on a path that the backend is discarding.
  assign eval_v       = cap_v_reg & (state_reg == RUN) & ~flush_i;
  assign npc_mismatch = (cap_npc_reg != cap_pred_reg);
  assign redirect_now = eval_v & (cap_mis_reg | npc_mismatch);
  assign attaboy_now  = eval_v & ~cap_mis_reg & ~npc_mismatch;

  // When the target is misaligned, the redirect reports a misaligned target
  // even if the next PC also mismatches.
  assign eval_reason  = cap_mis_reg ? reason_misaligned : {1'b0, cap_taken_reg};

  // -------------------------------------------------------------------------
  // Held redirect payload
  // -------------------------------------------------------------------------
  logic [vaddr_width_p-1:0] redir_npc_reg;
  logic [vaddr_width_p-1:0] redir_pc_reg;
  logic [1:0]               redir_reason_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      redir_npc_reg    <= '0;
      redir_pc_reg     <= '0;
      redir_reason_reg <= 2'd0;
    end else if (redirect_now) begin
      redir_npc_reg    <= cap_npc_reg;
      redir_pc_reg     <= cap_pc_reg;
      redir_reason_reg <= eval_reason;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // The redirect is first presented in the evaluate cycle, so the latency from
  // v_i is exactly one cycle. If the frontend accepts it in that same cycle,
  // the unit skips SEND and goes straight to SQUASH. This prevents the same
  // redirect from being offered a second time. A flush during SEND does not
  // withdraw the command; it only changes where the unit goes after the
  // handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (redirect_now) begin
          state_next = redirect_ready_i ? SQUASH : SEND;
        end
      end
      SEND: begin
        if (redirect_ready_i) begin
          state_next = flush_i ? RUN : SQUASH;
        end
      end
      SQUASH: begin
        if (flush_i) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic in_send;
  assign in_send = (state_reg == SEND);

  assign busy_o = (state_reg != RUN);

  // redirect_v_o is built only from state and captured data. It does not
  // depend on redirect_ready_i.
  assign redirect_v_o      = in_send | redirect_now;
  assign redirect_npc_o    = in_send      ? redir_npc_reg    :
                             redirect_now ? cap_npc_reg      : '0;
  assign redirect_pc_o     = in_send      ? redir_pc_reg     :
                             redirect_now ? cap_pc_reg       : '0;
  assign redirect_reason_o = in_send      ? redir_reason_reg :
                             redirect_now ? eval_reason      : 2'd0;

  assign attaboy_v_o     = attaboy_now;
  assign attaboy_pc_o    = attaboy_now ? cap_pc_reg : '0;
  assign attaboy_taken_o = attaboy_now & cap_taken_reg;

  // -------------------------------------------------------------------------
  // Saturating statistics
  // -------------------------------------------------------------------------
  logic [cnt_width_p-1:0] branch_cnt_reg;
  logic [cnt_width_p-1:0] mispredict_cnt_reg;
  logic                   mispredict_inc;

  // A misaligned target is counted as a branch but not as a mispredict.
  assign mispredict_inc = redirect_now & ~cap_mis_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (eval_v && (branch_cnt_reg != '1)) begin
        branch_cnt_reg <= branch_cnt_reg + 1'b1;
      end
      if (mispredict_inc && (mispredict_cnt_reg != '1)) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
      end
    end
  end

  assign branch_cnt_o     = branch_cnt_reg;
  assign mispredict_cnt_o = mispredict_cnt_reg;

endmodule

// File: tb/tb_bp_be_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_bp_be_branch_resolve
//
// Directed testbench for bp_be_branch_resolve. The counters are 4 bits wide so
// that saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_bp_be_branch_resolve;

  localparam int VW = 39;
  localparam int CW = 4;

  logic          clk_i;
  logic          reset_n_i;
  logic          v_i;
  logic          branch_i;
  logic          btaken_i;
  logic [VW-1:0] npc_i;
  logic [VW-1:0] pred_npc_i;
  logic [VW-1:0] pc_i;
  logic          misaligned_i;
  logic          flush_i;
  logic          busy_o;
  logic          redirect_v_o;
  logic          redirect_ready_i;
  logic [VW-1:0] redirect_npc_o;
  logic [VW-1:0] redirect_pc_o;
  logic [1:0]    redirect_reason_o;
  logic          attaboy_v_o;
  logic [VW-1:0] attaboy_pc_o;
  logic          attaboy_taken_o;
  logic [CW-1:0] branch_cnt_o;
  logic [CW-1:0] mispredict_cnt_o;

  int test_cnt = 0;
  int fail_cnt = 0;

  bp_be_branch_resolve #(
    .vaddr_width_p(VW),
    .cnt_width_p  (CW)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .v_i              (v_i),
    .branch_i         (branch_i),
    .btaken_i         (btaken_i),
    .npc_i            (npc_i),
    .pred_npc_i       (pred_npc_i),
    .pc_i             (pc_i),
    .misaligned_i     (misaligned_i),
    .flush_i          (flush_i),
    .busy_o           (busy_o),
    .redirect_v_o     (redirect_v_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_npc_o   (redirect_npc_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_reason_o(redirect_reason_o),
    .attaboy_v_o      (attaboy_v_o),
    .attaboy_pc_o     (attaboy_pc_o),
    .attaboy_taken_o  (attaboy_taken_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    v_i          = 1'b0;
    branch_i     = 1'b0;
    btaken_i     = 1'b0;
    misaligned_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic drive(input logic taken, input logic mis, input logic [VW-1:0] pc,
                       input logic [VW-1:0] npc, input logic [VW-1:0] pred);
    v_i          = 1'b1;
    branch_i     = 1'b1;
    btaken_i     = taken;
    misaligned_i = mis;
    pc_i         = pc;
    npc_i        = npc;
    pred_npc_i   = pred;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    redirect_ready_i = 1'b0;
    pc_i = '0; npc_i = '0; pred_npc_i = '0;
    idle();
    tick(); tick();
    test_cnt++; if (redirect_v_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_redirect_v got %b exp 0", redirect_v_o); end
    test_cnt++; if (attaboy_v_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_attaboy_v got %b exp 0", attaboy_v_o); end
    test_cnt++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    test_cnt++; if (branch_cnt_o !== 4'd0) begin fail_cnt++; $display("FAIL reset_branch_cnt got %0d exp 0", branch_cnt_o); end
    test_cnt++; if (mispredict_cnt_o !== 4'd0) begin fail_cnt++; $display("FAIL reset_mispredict_cnt got %0d exp 0", mispredict_cnt_o); end
    #2 reset_n_i = 1'b1;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_correct_taken();
    drive(1'b1, 1'b0, 39'hFFC, 39'h1000, 39'h1000);
    tick(); idle(); #1;
    test_cnt++; if (attaboy_v_o !== 1'b1) begin fail_cnt++; $display("FAIL ct_attaboy_v got %b exp 1", attaboy_v_o); end
    test_cnt++; if (attaboy_pc_o !== 39'hFFC) begin fail_cnt++; $display("FAIL ct_attaboy_pc got %h exp ffc", attaboy_pc_o); end
    test_cnt++; if (attaboy_taken_o !== 1'b1) begin fail_cnt++; $display("FAIL ct_attaboy_taken got %b exp 1", attaboy_taken_o); end
    test_cnt++; if (redirect_v_o !== 1'b0) begin fail_cnt++; $display("FAIL ct_redirect_v got %b exp 0", redirect_v_o); end
    tick();
    test_cnt++; if (attaboy_v_o !== 1'b0) begin fail_cnt++; $display("FAIL ct_attaboy_pulse got %b exp 0", attaboy_v_o); end
    test_cnt++; if (branch_cnt_o !== 4'd1) begin fail_cnt++; $display("FAIL ct_branch_cnt got %0d exp 1", branch_cnt_o); end
    test_cnt++; if (mispredict_cnt_o !== 4'd0) begin fail_cnt++; $display("FAIL ct_mispredict_cnt got %0d exp 0", mispredict_cnt_o); end
    $display("[TB] test_correct_taken done");
  endtask

  task automatic test_non_branch();
    drive(1'b1, 1'b0, 39'h2000, 39'h2400, 39'h2004);
    branch_i = 1'b0;
    tick(); idle(); #1;
    test_cnt++; if ((redirect_v_o | attaboy_v_o) !== 1'b0) begin fail_cnt++; $display("FAIL nb_outputs got r=%b a=%b exp 0", redirect_v_o, attaboy_v_o); end
    tick();
    test_cnt++; if (branch_cnt_o !== 4'd1) begin fail_cnt++; $display("FAIL nb_branch_cnt got %0d exp 1", branch_cnt_o); end
    $display("[TB] test_non_branch done");
  endtask

  task automatic test_mispredict_hold();
    redirect_ready_i = 1'b0;
    drive(1'b1, 1'b0, 39'h1100, 39'h2000, 39'h1004);
    tick(); idle(); #1;
    test_cnt++; if (redirect_v_o !== 1'b1) begin fail_cnt++; $display("FAIL mp_redirect_v got %b exp 1", redirect_v_o); end
    test_cnt++; if (redirect_npc_o !== 39'h2000) begin fail_cnt++; $display("FAIL mp_npc got %h exp 2000", redirect_npc_o); end
    test_cnt++; if (redirect_pc_o !== 39'h1100) begin fail_cnt++; $display("FAIL mp_pc got %h exp 1100", redirect_pc_o); end
    test_cnt++; if (redirect_reason_o !== 2'd1) begin fail_cnt++; $display("FAIL mp_reason got %0d exp 1", redirect_reason_o); end
    test_cnt++; if (attaboy_v_o !== 1'b0) begin fail_cnt++; $display("FAIL mp_attaboy got %b exp 0", attaboy_v_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      test_cnt++; if (redirect_v_o !== 1'b1 || redirect_npc_o !== 39'h2000 || redirect_reason_o !== 2'd1 || busy_o !== 1'b1) begin
        fail_cnt++; $display("FAIL mp_hold%0d got v=%b npc=%h r=%0d busy=%b exp 1/2000/1/1", i, redirect_v_o, redirect_npc_o, redirect_reason_o, busy_o);
      end
    end
    test_cnt++; if (branch_cnt_o !== 4'd2 || mispredict_cnt_o !== 4'd1) begin fail_cnt++; $display("FAIL mp_cnts got %0d/%0d exp 2/1", branch_cnt_o, mispredict_cnt_o); end
    redirect_ready_i = 1'b1;
    tick(); redirect_ready_i = 1'b0; #1;
    test_cnt++; if (redirect_v_o !== 1'b0 || busy_o !== 1'b1) begin fail_cnt++; $display("FAIL mp_squash got v=%b busy=%b exp 0/1", redirect_v_o, busy_o); end
    drive(1'b0, 1'b0, 39'h2000, 39'h2004, 39'h3000);
    tick(); idle(); #1;
    test_cnt++; if ((redirect_v_o | attaboy_v_o) !== 1'b0) begin fail_cnt++; $display("FAIL mp_squash_drop got r=%b a=%b exp 0", redirect_v_o, attaboy_v_o); end
    tick();
    test_cnt++; if (branch_cnt_o !== 4'd2 || mispredict_cnt_o !== 4'd1) begin fail_cnt++; $display("FAIL mp_squash_cnts got %0d/%0d exp 2/1", branch_cnt_o, mispredict_cnt_o); end
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    test_cnt++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL mp_flush_run got busy=%b exp 0", busy_o); end
    $display("[TB] test_mispredict_hold done");
  endtask

  task automatic test_misaligned();
    redirect_ready_i = 1'b0;
    drive(1'b1, 1'b1, 39'h1200, 39'h1002, 39'h1004);
    tick(); idle(); #1;
    test_cnt++; if (redirect_v_o !== 1'b1 || redirect_reason_o !== 2'd2) begin fail_cnt++; $display("FAIL ma_redirect got v=%b r=%0d exp 1/2", redirect_v_o, redirect_reason_o); end
    test_cnt++; if (redirect_npc_o !== 39'h1002 || redirect_pc_o !== 39'h1200) begin fail_cnt++; $display("FAIL ma_payload got %h/%h exp 1002/1200", redirect_npc_o, redirect_pc_o); end
    tick();
    test_cnt++; if (branch_cnt_o !== 4'd3 || mispredict_cnt_o !== 4'd1) begin fail_cnt++; $display("FAIL ma_cnts got %0d/%0d exp 3/1", branch_cnt_o, mispredict_cnt_o); end
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    test_cnt++; if (redirect_v_o !== 1'b1 || redirect_reason_o !== 2'd2 || busy_o !== 1'b1) begin fail_cnt++; $display("FAIL ma_flush_only got v=%b r=%0d busy=%b exp 1/2/1", redirect_v_o, redirect_reason_o, busy_o); end
    $display("[TB] test_misaligned done");
  endtask

  task automatic test_ready_flush();
    redirect_ready_i = 1'b1;
    flush_i = 1'b1;
    tick(); redirect_ready_i = 1'b0; flush_i = 1'b0; #1;
    test_cnt++; if (busy_o !== 1'b0 || redirect_v_o !== 1'b0) begin fail_cnt++; $display("FAIL rf_run got busy=%b v=%b exp 0/0", busy_o, redirect_v_o); end
    drive(1'b0, 1'b0, 39'h1300, 39'h1304, 39'h1304);
    tick(); idle(); #1;
    test_cnt++; if (attaboy_v_o !== 1'b1 || attaboy_pc_o !== 39'h1300 || attaboy_taken_o !== 1'b0) begin
      fail_cnt++; $display("FAIL rf_accept got a=%b pc=%h t=%b exp 1/1300/0", attaboy_v_o, attaboy_pc_o, attaboy_taken_o);
    end
    tick();
    test_cnt++; if (branch_cnt_o !== 4'd4) begin fail_cnt++; $display("FAIL rf_branch_cnt got %0d exp 4", branch_cnt_o); end
    $display("[TB] test_ready_flush done");
  endtask

  task automatic test_flush_capture();
    drive(1'b1, 1'b0, 39'h1500, 39'h1600, 39'h1504);
    tick(); idle(); flush_i = 1'b1; #1;
    test_cnt++; if ((redirect_v_o | attaboy_v_o) !== 1'b0) begin fail_cnt++; $display("FAIL fc_outputs got r=%b a=%b exp 0", redirect_v_o, attaboy_v_o); end
    tick(); flush_i = 1'b0; #1;
    test_cnt++; if (busy_o !== 1'b0 || branch_cnt_o !== 4'd4 || mispredict_cnt_o !== 4'd1) begin
      fail_cnt++; $display("FAIL fc_state got busy=%b cnt=%0d/%0d exp 0/4/1", busy_o, branch_cnt_o, mispredict_cnt_o);
    end
    $display("[TB] test_flush_capture done");
  endtask

  task automatic test_ready_in_eval();
    drive(1'b0, 1'b0, 39'h1400, 39'h1404, 39'h1800);
    tick(); idle(); redirect_ready_i = 1'b1; #1;
    test_cnt++; if (redirect_v_o !== 1'b1 || redirect_reason_o !== 2'd0 || redirect_npc_o !== 39'h1404) begin
      fail_cnt++; $display("FAIL re_redirect got v=%b r=%0d npc=%h exp 1/0/1404", redirect_v_o, redirect_reason_o, redirect_npc_o);
    end
    tick(); redirect_ready_i = 1'b0; #1;
    test_cnt++; if (redirect_v_o !== 1'b0 || busy_o !== 1'b1) begin fail_cnt++; $display("FAIL re_squash got v=%b busy=%b exp 0/1", redirect_v_o, busy_o); end
    test_cnt++; if (branch_cnt_o !== 4'd5 || mispredict_cnt_o !== 4'd2) begin fail_cnt++; $display("FAIL re_cnts got %0d/%0d exp 5/2", branch_cnt_o, mispredict_cnt_o); end
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    test_cnt++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL re_run got busy=%b exp 0", busy_o); end
    $display("[TB] test_ready_in_eval done");
  endtask

  task automatic test_async_reset();
    redirect_ready_i = 1'b0;
    drive(1'b1, 1'b0, 39'h4FFC, 39'h5000, 39'h5004);
    tick(); idle(); tick();
    test_cnt++; if (redirect_v_o !== 1'b1 || busy_o !== 1'b1) begin fail_cnt++; $display("FAIL ar_send got v=%b busy=%b exp 1/1", redirect_v_o, busy_o); end
    #2 reset_n_i = 1'b0;
    #1;
    test_cnt++; if (redirect_v_o !== 1'b0 || busy_o !== 1'b0) begin fail_cnt++; $display("FAIL ar_outputs got v=%b busy=%b exp 0/0", redirect_v_o, busy_o); end
    test_cnt++; if (branch_cnt_o !== 4'd0 || mispredict_cnt_o !== 4'd0) begin fail_cnt++; $display("FAIL ar_cnts got %0d/%0d exp 0/0", branch_cnt_o, mispredict_cnt_o); end
    #1 reset_n_i = 1'b1;
    tick();
    drive(1'b1, 1'b0, 39'h6000, 39'h6100, 39'h6100);
    tick(); idle(); #1;
    test_cnt++; if (attaboy_v_o !== 1'b1) begin fail_cnt++; $display("FAIL ar_run_attaboy got %b exp 1", attaboy_v_o); end
    tick();
    test_cnt++; if (branch_cnt_o !== 4'd1 || busy_o !== 1'b0) begin fail_cnt++; $display("FAIL ar_after got cnt=%0d busy=%b exp 1/0", branch_cnt_o, busy_o); end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] pc;
    for (int i = 0; i < 20; i++) begin
      pc = 39'h3000 + VW'(4 * i);
      drive(i[0], 1'b0, pc, pc + 39'd4, pc + 39'd4);
      tick(); #1;
      test_cnt++; if (attaboy_v_o !== 1'b1 || attaboy_pc_o !== pc || attaboy_taken_o !== i[0]) begin
        fail_cnt++; $display("FAIL b2b_%0d got a=%b pc=%h t=%b exp 1/%h/%b", i, attaboy_v_o, attaboy_pc_o, attaboy_taken_o, pc, i[0]);
      end
    end
    idle();
    tick();
    test_cnt++; if (branch_cnt_o !== 4'd15) begin fail_cnt++; $display("FAIL b2b_saturate got %0d exp 15", branch_cnt_o); end
    test_cnt++; if (mispredict_cnt_o !== 4'd0 || attaboy_v_o !== 1'b0) begin fail_cnt++; $display("FAIL b2b_tail got mis=%0d a=%b exp 0/0", mispredict_cnt_o, attaboy_v_o); end
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_non_branch();
    test_mispredict_hold();
    test_misaligned();
    test_ready_flush();
    test_flush_capture();
    test_ready_in_eval();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
